// File: rtl/rx_frame_qualifier.sv
// Byte-stream frame qualifier: output register plus 1-entry skid buffer, flags bad frames on tlast.
// Optional RX_FRAME_STATS_EN adds good/bad frame counters on the output side.
module rx_frame_qualifier #(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic       s_axis_trdy,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  input  logic       m_axis_trdy
`ifdef RX_FRAME_STATS_EN
  ,
  output logic [31:0] good_frame_cnt,
  output logic [31:0] bad_frame_cnt
`endif
);

  // state  | meaning
  // IDLE   | awaiting first beat of a frame
  // ACTIVE | mid-frame, counter and sticky error are live
  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_LEN);
  localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_LEN);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        s_trdy_q, s_trdy_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_last_q, out_last_d;
  logic        out_user_q, out_user_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  skid_data_q, skid_data_d;
  logic        skid_last_q, skid_last_d;
  logic        skid_user_q, skid_user_d;
  logic        skid_valid_q, skid_valid_d;

  logic        accept;
  logic        out_ready;
  logic [15:0] len_beat;
  logic        err_beat;
  logic        bad_beat;

  always_comb begin
    accept    = s_axis_tvalid & s_trdy_q;
    out_ready = ~out_valid_q | m_axis_trdy;
    // Length and error as they stand including the beat now on the input.
    if (state_q == IDLE) begin
      len_beat = 16'd1;
      err_beat = s_axis_tuser;
    end else begin
      len_beat = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
      err_beat = err_q | s_axis_tuser;
    end
    bad_beat = s_axis_tlast & (err_beat | (len_beat < MIN_LEN) | (len_beat > MAX_LEN));

    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_user_d   = out_user_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    skid_user_d  = skid_user_q;
    skid_valid_d = skid_valid_q;

    if (accept) begin
      if (s_axis_tlast) begin
        state_d = IDLE;
        cnt_d   = 16'd0;
        err_d   = 1'b0;
      end else begin
        state_d = ACTIVE;
        cnt_d   = len_beat;
        err_d   = err_beat;
      end
    end

    // Input is only accepted while the skid is empty, so skid and accept never collide.
    if (out_ready) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        out_user_d   = skid_user_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_data_d  = s_axis_tdata;
        out_last_d  = s_axis_tlast;
        out_user_d  = bad_beat;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_data_d  = s_axis_tdata;
      skid_last_d  = s_axis_tlast;
      skid_user_d  = bad_beat;
      skid_valid_d = 1'b1;
    end

    s_trdy_d = ~skid_valid_d;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= IDLE;
      cnt_q        <= 16'd0;
      err_q        <= 1'b0;
      s_trdy_q     <= 1'b0;
      out_data_q   <= 8'h00;
      out_last_q   <= 1'b0;
      out_user_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= 8'h00;
      skid_last_q  <= 1'b0;
      skid_user_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      s_trdy_q     <= s_trdy_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_user_q   <= out_user_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      skid_user_q  <= skid_user_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign s_axis_trdy   = s_trdy_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tuser  = out_user_q;

`ifdef RX_FRAME_STATS_EN
  logic [31:0] good_q, bad_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      good_q <= 32'd0;
      bad_q  <= 32'd0;
    end else if (out_valid_q & m_axis_trdy & out_last_q) begin
      if (out_user_q) bad_q  <= bad_q + 32'd1;
      else            good_q <= good_q + 32'd1;
    end
  end

  assign good_frame_cnt = good_q;
  assign bad_frame_cnt  = bad_q;
`endif

endmodule

// File: tb/tb_rx_frame_qualifier.sv
// Scoreboard bench for rx_frame_qualifier: driver pushes hand-computed expected beats, monitor pops on each output transfer.
module tb_rx_frame_qualifier;

  logic       aclk = 1'b0;
  logic       areset = 1'b1;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tvalid = 1'b0;
  logic       s_tlast = 1'b0;
  logic       s_tuser = 1'b0;
  logic       s_trdy;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tlast;
  logic       m_tuser;
  logic       m_trdy = 1'b1;
`ifdef RX_FRAME_STATS_EN
  logic [31:0] good_cnt;
  logic [31:0] bad_cnt;
`endif

  rx_frame_qualifier #(.MIN_FRAME_LEN(64), .MAX_FRAME_LEN(1518)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .s_axis_trdy   (s_trdy),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .m_axis_trdy   (m_trdy)
`ifdef RX_FRAME_STATS_EN
    ,
    .good_frame_cnt (good_cnt),
    .bad_frame_cnt  (bad_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       u;
    int         acc;
    logic       lat;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic armed = 1'b0;
  logic rand_mode = 1'b0;
  logic chk_lat = 1'b0;

  always @(posedge aclk) begin
    cyc   <= cyc + 1;
    armed <= ~areset;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // m_axis_trdy stall pattern, changed just after each rising edge
  always begin
    @(posedge aclk);
    #1;
    if (rand_mode) m_trdy = 1'($urandom_range(0, 1));
  end

  task automatic send_beat(input logic [7:0] d, input logic l, input logic u_in, input logic exp_u);
    int n = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tuser  = u_in;
    s_tvalid = 1'b1;
    forever begin
      @(negedge aclk);
      if (s_trdy) break;
      n++;
      if (n > 1000) begin
        chk("accept_timeout", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge aclk);
    #1;
    q.push_back('{d: d, l: l, u: exp_u, acc: cyc, lat: chk_lat});
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic send_frame(input int len, input int err_at, input logic exp_bad);
    for (int i = 1; i <= len; i++)
      send_beat(8'(i - 1), (i == len), (i == err_at), (i == len) ? exp_bad : 1'b0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(posedge aclk);
      n++;
    end
    chk("drain_left", 32'(q.size()), 32'd0);
    @(posedge aclk);
    #1;
  endtask

  // Monitor: reset values, stall stability, skid occupancy vs s_axis_trdy, scoreboard pops.
  initial begin
    logic       prev_stall = 1'b0;
    logic [7:0] prev_d = 8'h00;
    logic       prev_l = 1'b0;
    logic       prev_u = 1'b0;
    exp_t       e;
    forever begin
      @(negedge aclk);
      if (areset) begin
        chk("reset_outputs", {20'd0, m_tvalid, m_tlast, m_tuser, m_tdata, s_trdy}, 32'd0);
        prev_stall = 1'b0;
      end else begin
        if (armed) chk("trdy_vs_skid", 32'(s_trdy), 32'(q.size() < 2));
        if (prev_stall)
          chk("stall_hold", {21'd0, m_tvalid, m_tlast, m_tuser, m_tdata}, {21'd0, 1'b1, prev_l, prev_u, prev_d});
        if (m_tvalid && m_trdy) begin
          if (q.size() == 0) begin
            chk("unexpected_beat", {24'd0, m_tdata}, 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            chk("beat_data", {24'd0, m_tdata}, {24'd0, e.d});
            chk("beat_last", 32'(m_tlast), 32'(e.l));
            chk("beat_user", 32'(m_tuser), 32'(e.u));
            if (e.lat) chk("latency", 32'(cyc + 1 - e.acc), 32'd1);
          end
        end
        prev_stall = m_tvalid && !m_trdy;
        prev_d = m_tdata;
        prev_l = m_tlast;
        prev_u = m_tuser;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;

    chk_lat = 1'b1;
    send_frame(64, 0, 1'b0);
    wait_drain();
    chk_lat = 1'b0;

    send_frame(63, 0, 1'b1);
    send_frame(1519, 0, 1'b1);
    send_frame(1518, 0, 1'b0);
    send_frame(100, 10, 1'b1);
    send_frame(1, 0, 1'b1);
    send_frame(64, 0, 1'b0);
    wait_drain();

    rand_mode = 1'b1;
    send_frame(200, 0, 1'b0);
    wait_drain();
    rand_mode = 1'b0;
    @(posedge aclk);
    #1;
    m_trdy = 1'b1;

`ifdef RX_FRAME_STATS_EN
    chk("good_cnt_pre", good_cnt, 32'd4);
    chk("bad_cnt_pre", bad_cnt, 32'd4);
`endif

    // Partial frame cut by reset after byte 30.
    for (int i = 1; i <= 30; i++) send_beat(8'(i - 1), 1'b0, 1'b0, 1'b0);
    areset = 1'b1;
    q.delete();
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;
    send_frame(64, 0, 1'b0);
    wait_drain();

`ifdef RX_FRAME_STATS_EN
    chk("good_cnt_post", good_cnt, 32'd1);
    chk("bad_cnt_post", bad_cnt, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
